mdio_master: RTL and testbench
==============================

# mdio_master

Parametrised MDIO management master for the Ethernet subsystem. It serialises PHY register accesses from a single-command valid/ready port onto MDC/MDIO. It supports IEEE 802.3 Clause 22 and, when enabled, Clause 45 frames, with a configurable MDC divider and preamble length. It sits between the control fabric and the board PHY pins that feed the TSE MAC's MDIO connection, and it reports every completed frame as a response carrying read data and a PHY-absent error flag.

## Interface
- CLK_DIV, 10: system clocks per MDC half-period; legal range ≥2.
- PREAMBLE_LEN, 32: number of preamble '1' bits; legal range 0..32. A value of 0 gives preamble suppression.
- CLAUSE45_EN, 1: 1 accepts Clause 45 commands; 0 forces every command to Clause 22.

Ports:
- clk_clk  in  1  system clock; all logic is on the rising edge.
- reset_reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high in IDLE only; a command is accepted on cycle N when cmd_valid && cmd_ready.
- cmd_c45  in  1  1 selects a Clause 45 frame; ignored when CLAUSE45_EN=0.
- cmd_op  in  2  MDIO OP field.
  - C22: 01 write, 10 read.
  - C45: 00 address, 01 write, 11 read, 10 read-increment.
- cmd_phy  in  5  PHYAD/PRTAD.
- cmd_reg  in  5  REGAD/DEVAD.
- cmd_data  in  16  write data, or the address for a C45 address frame.
- rsp_valid  out  1  one-cycle pulse per completed or rejected command.
- rsp_data  out  16  captured read data; 0 for non-read frames; held until the next rsp_valid.
- rsp_err  out  1  PHY-absent or illegal-command flag; held with rsp_data.
- busy  out  1  high from the acceptance cycle N through the rsp_valid cycle.
- mdc  out  1  management clock; low when idle.
- mdio_in  in  1  MDIO pad input.
- mdio_out  out  1  MDIO pad output value.
- mdio_oen  out  1  active-low output enable: 0 drives the pad, 1 releases it.

## Operation
- States: IDLE, SHIFT, DONE.
  - IDLE→SHIFT on acceptance.
  - SHIFT→DONE after the high phase of the last bit.
  - DONE→IDLE after one cycle; rsp_valid=1 in DONE.
- Frame bit index b runs from 0 to P+31, where P=PREAMBLE_LEN:
  - b<P: preamble, '1'.
  - P, P+1: ST; 01 for C22, 00 for C45.
  - P+2, P+3: OP.
  - P+4..P+8: PHY, MSB first.
  - P+9..P+13: REG, MSB first.
  - P+14, P+15: TA.
  - P+16..P+31: DATA, MSB first.
- Write and address frames:
  - TA is driven as 1,0.
  - mdio_oen=0 for the whole frame.
- Read frames (C22 op 10; C45 ops 11 and 10):
  - mdio_oen=0 for b<P+14 and 1 from b=P+14 to the end of the frame.
  - mdio_in is sampled at b=P+15; a value of 1 sets rsp_err.
  - DATA bits are sampled and shifted MSB first.
- Illegal commands:
  - A C22 command with op 00 or 11 is rejected with no frame.
  - DONE is entered on N+1, with rsp_err=1 and rsp_data=0.
- rsp_err is set to 0 for every legal write or address frame.
- Outside SHIFT: mdc=0, mdio_out=1, mdio_oen=1.
- Reset values: mdc=0, mdio_out=1, mdio_oen=1, cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0. cmd_ready=1 from the first cycle after reset deasserts.
- Reset mid-frame: the frame is abandoned, all outputs take reset values on the next cycle, and no rsp_valid is generated.

## Timing
- Each bit lasts 2×CLK_DIV cycles: a low phase of CLK_DIV cycles, then a high phase of CLK_DIV cycles.
- Bit b starts on cycle S_b = N+1+b×2×CLK_DIV.
  - On S_b, mdc falls (or stays 0 for b=0) and mdio_out/mdio_oen update.
  - mdc rises on S_b+CLK_DIV.
- Read sampling: mdio_in is registered on the cycle mdc rises, i.e. S_b+CLK_DIV.
- Completion: rsp_valid occurs on cycle N+1+(P+32)×2×CLK_DIV, which is the DONE cycle. cmd_ready returns high on the following cycle.
- Back-to-back: the minimum command spacing is (P+32)×2×CLK_DIV+2 cycles. cmd_valid held high is not accepted while busy.
- The rsp_data and rsp_err updates coincide with the rsp_valid pulse.

## Test plan
- C22 write, CLK_DIV=2, P=32: phy=01, reg=00, data=1140.
  - The mdio_out bit stream equals 32 ones, then 01 01 00001 00000 10 0001000101000000.
  - mdio_oen stays 0 throughout the frame.
  - rsp_valid occurs at N+257 with err=0.
- C22 read: a PHY model drives 796D after TA=z,0.
  - mdio_oen rises at bit 46.
  - rsp_data=796D, err=0.
- C22 read with mdio_in held at 1 (no PHY): rsp_data=FFFF, err=1.
- CLAUSE45_EN=1, P=0: address frame dev=1, data=0007, followed by a read-increment.
  - ST=00, OP=00, then OP=10 on the second frame.
  - rsp_valid for each frame at N+65 (CLK_DIV=1 is illegal; use CLK_DIV=2, giving N+129).
- Illegal C22 op 11: rsp_valid on N+1 with err=1, no mdc toggling.
- Reset asserted at bit 20 of a write: the next cycle shows mdc=0, mdio_oen=1, no rsp_valid; a subsequent command then completes normally.

Source files
------------

// File: rtl/mdio_master.sv
// rtl/mdio_master.sv - MDIO management master for Clause 22 / Clause 45 PHY access
//
// Serialises one PHY register access at a time onto MDC/MDIO and returns a
// response with the captured read data and an error flag.
//
// Parameters:
//   CLK_DIV       system clocks per MDC half-period (>= 2)
//   PREAMBLE_LEN  number of leading '1' preamble bits (0..32)
//   CLAUSE45_EN   1 honours cmd_c45, 0 treats every command as Clause 22
//
// Ports:
//   clk_clk, reset_reset          clock, synchronous active-high reset
//   cmd_valid / cmd_ready         command handshake (ready only in IDLE)
//   cmd_c45, cmd_op, cmd_phy,     frame fields: clause select, OP, PHYAD/PRTAD,
//   cmd_reg, cmd_data             REGAD/DEVAD, write data or C45 address
//   rsp_valid, rsp_data, rsp_err  one-cycle response pulse with held data/error
//   busy                          acceptance cycle through response cycle
//   mdc, mdio_in, mdio_out,       management clock and pad signals;
//   mdio_oen                      mdio_oen is active-low (0 drives the pad)

module mdio_master #(
  parameter int CLK_DIV      = 10,
  parameter int PREAMBLE_LEN = 32,
  parameter bit CLAUSE45_EN  = 1'b1
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_c45,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_phy,
  input  logic [4:0]  cmd_reg,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic        mdc,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_oen
);

  localparam int PW = $clog2(2 * CLK_DIV);

  // Phase within a bit: low half 0..CLK_DIV-1, high half CLK_DIV..2*CLK_DIV-1.
  localparam logic [PW-1:0] PH_RISE = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_LAST = PW'(2 * CLK_DIV - 1);

  // Frame bit indices relative to the end of the preamble.
  localparam logic [6:0] B_TA1  = 7'(PREAMBLE_LEN + 14);
  localparam logic [6:0] B_TA2  = 7'(PREAMBLE_LEN + 15);
  localparam logic [6:0] B_DAT  = 7'(PREAMBLE_LEN + 16);
  localparam logic [6:0] B_LAST = 7'(PREAMBLE_LEN + 31);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [6:0]    bit_q, bit_d;
  logic [62:0]   sreg_q, sreg_d;      // bits still to be sent after the current one
  logic          read_q, read_d;
  logic          ta_err_q, ta_err_d;
  logic [15:0]   rdata_q, rdata_d;
  logic          mdc_q, mdc_d;
  logic          mdio_out_q, mdio_out_d;
  logic          mdio_oen_q, mdio_oen_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [15:0]   rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;

  logic          cmd_fire;
  logic          c45;
  logic          legal;
  logic          rd;
  logic [31:0]   frame;
  logic [63:0]   load;
  logic [6:0]    bit_nx;

  assign cmd_fire = cmd_valid && cmd_ready_q;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bit_d       = bit_q;
    sreg_d      = sreg_q;
    read_d      = read_q;
    ta_err_d    = ta_err_q;
    rdata_d     = rdata_q;
    mdc_d       = mdc_q;
    mdio_out_d  = mdio_out_q;
    mdio_oen_d  = mdio_oen_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    c45    = CLAUSE45_EN && cmd_c45;
    legal  = c45 || (cmd_op == 2'b01) || (cmd_op == 2'b10);
    rd     = c45 ? cmd_op[1] : (cmd_op == 2'b10);
    // Read frames send all ones during TA/DATA; the pad is released then anyway.
    frame  = {(c45 ? 2'b00 : 2'b01), cmd_op, cmd_phy, cmd_reg,
              (rd ? 18'h3FFFF : {2'b10, cmd_data})};
    // Preamble ones on top, frame directly below, unused tail at the bottom.
    load   = {32'hFFFF_FFFF, frame} << (32 - PREAMBLE_LEN);
    bit_nx = bit_q + 7'd1;

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_fire) begin
          cmd_ready_d = 1'b0;
          if (!legal) begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            rsp_data_d  = 16'h0000;
            rsp_err_d   = 1'b1;
          end else begin
            state_d    = SHIFT;
            sreg_d     = load[62:0];
            read_d     = rd;
            bit_d      = 7'd0;
            phase_d    = '0;
            ta_err_d   = 1'b0;
            rdata_d    = 16'h0000;
            mdc_d      = 1'b0;
            mdio_out_d = load[63];
            mdio_oen_d = 1'b0;
          end
        end
      end

      SHIFT: begin
        phase_d = phase_q + 1'b1;
        if (phase_q == PH_RISE) begin
          // mdc rises on the next cycle; capture the PHY's bit alongside it.
          mdc_d = 1'b1;
          if (read_q && (bit_q == B_TA2)) begin
            ta_err_d = mdio_in;
          end
          if (read_q && (bit_q >= B_DAT)) begin
            rdata_d = {rdata_q[14:0], mdio_in};
          end
        end
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          mdc_d   = 1'b0;
          if (bit_q == B_LAST) begin
            state_d     = DONE;
            mdio_out_d  = 1'b1;
            mdio_oen_d  = 1'b1;
            rsp_valid_d = 1'b1;
            rsp_data_d  = read_q ? rdata_q : 16'h0000;
            rsp_err_d   = read_q && ta_err_q;
          end else begin
            bit_d      = bit_nx;
            mdio_out_d = sreg_q[62];
            sreg_d     = {sreg_q[61:0], 1'b1};
            mdio_oen_d = read_q && (bit_nx >= B_TA1);
          end
        end
      end

      DONE: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      bit_q       <= 7'd0;
      sreg_q      <= '0;
      read_q      <= 1'b0;
      ta_err_q    <= 1'b0;
      rdata_q     <= 16'h0000;
      mdc_q       <= 1'b0;
      mdio_out_q  <= 1'b1;
      mdio_oen_q  <= 1'b1;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 16'h0000;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      sreg_q      <= sreg_d;
      read_q      <= read_d;
      ta_err_q    <= ta_err_d;
      rdata_q     <= rdata_d;
      mdc_q       <= mdc_d;
      mdio_out_q  <= mdio_out_d;
      mdio_oen_q  <= mdio_oen_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  // Busy covers the acceptance cycle itself, before any state has changed.
  assign busy      = (state_q != IDLE) || cmd_fire;
  assign mdc       = mdc_q;
  assign mdio_out  = mdio_out_q;
  assign mdio_oen  = mdio_oen_q;

endmodule

// File: tb/tb_mdio_master.sv
// tb/tb_mdio_master.sv - directed scoreboard bench for mdio_master

module tb_mdio_master;

  localparam int D = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst;
  logic [1:0]  cmd_valid;
  logic        cmd_c45;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_phy;
  logic [4:0]  cmd_reg;
  logic [15:0] cmd_data;
  logic [1:0]  cmd_ready, rsp_valid, rsp_err, busy, mdc, mdio_out, mdio_oen;
  logic [15:0] rsp_data [2];
  logic        mdio_in_a;

  // Instance 0: Clause 22 only, full preamble. Instance 1: Clause 45, no preamble.
  mdio_master #(.CLK_DIV(D), .PREAMBLE_LEN(32), .CLAUSE45_EN(1'b0)) u_a (
    .clk_clk(clk), .reset_reset(rst),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_c45(cmd_c45),
    .cmd_op(cmd_op), .cmd_phy(cmd_phy), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0]),
    .busy(busy[0]), .mdc(mdc[0]), .mdio_in(mdio_in_a),
    .mdio_out(mdio_out[0]), .mdio_oen(mdio_oen[0]));

  mdio_master #(.CLK_DIV(D), .PREAMBLE_LEN(0), .CLAUSE45_EN(1'b1)) u_b (
    .clk_clk(clk), .reset_reset(rst),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_c45(cmd_c45),
    .cmd_op(cmd_op), .cmd_phy(cmd_phy), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1]),
    .busy(busy[1]), .mdc(mdc[1]), .mdio_in(1'b1),
    .mdio_out(mdio_out[1]), .mdio_oen(mdio_oen[1]));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int          dut;
    logic [15:0] data;
    logic        err;
    int          due;
    logic [63:0] strm;
    logic [63:0] oen;
    int          rises;
  } exp_t;

  exp_t sb[$];

  // PHY model for instance 0: releases TA as 1, drives 0, then the word MSB first.
  int          phy_n    = -1000;
  bit          phy_on   = 1'b0;
  logic [15:0] phy_word = 16'h0000;
  always @(negedge clk) begin : phy_model
    int rel;
    int b;
    rel = cyc - phy_n - 1;
    b   = rel / (2 * D);
    if (!phy_on || rel < 0 || b < 47 || b > 63) mdio_in_a = 1'b1;
    else if (b == 47) mdio_in_a = 1'b0;
    else mdio_in_a = phy_word[15 - (b - 48)];
  end

  // Records mdio_out/mdio_oen at each mdc rise and checks every response.
  logic [63:0] rec_s [2];
  logic [63:0] rec_o [2];
  int          rec_n [2];
  logic [1:0]  prev_mdc = 2'b00;
  always @(negedge clk) begin : monitor
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (!busy[i]) begin
        rec_s[i] = '0; rec_o[i] = '0; rec_n[i] = 0;
      end else if (mdc[i] && !prev_mdc[i]) begin
        rec_s[i] = {rec_s[i][62:0], mdio_out[i]};
        rec_o[i] = {rec_o[i][62:0], mdio_oen[i]};
        rec_n[i]++;
      end
      prev_mdc[i] = mdc[i];
      if (rsp_valid[i]) begin
        total++;
        assert (sb.size() != 0 && sb[0].dut == i) else begin
          bad++;
          $error("FAIL rsp_unexpected dut=%0d observed=rsp_valid expected=none cyc=%0d", i, cyc);
        end
        if (sb.size() != 0 && sb[0].dut == i) begin
          e = sb.pop_front();
          chk("rsp_data",    64'(rsp_data[i]), 64'(e.data));
          chk("rsp_err",     64'(rsp_err[i]),  64'(e.err));
          chk("rsp_cycle",   64'(cyc),         64'(e.due));
          chk("mdio_stream", rec_s[i],         e.strm);
          chk("mdio_oen",    rec_o[i],         e.oen);
          chk("mdc_rises",   64'(rec_n[i]),    64'(e.rises));
        end
        rec_s[i] = '0; rec_o[i] = '0; rec_n[i] = 0;
      end
    end
  end

  task automatic issue(input int dut, input logic c45, input logic [1:0] op,
                       input logic [4:0] phy, input logic [4:0] rg, input logic [15:0] wd,
                       input bit push, input int lat, input logic [15:0] e_data,
                       input logic e_err, input logic [63:0] e_strm,
                       input logic [63:0] e_oen, input int e_rises, output int n);
    int   k;
    exp_t e;
    @(negedge clk);
    cmd_c45 = c45; cmd_op = op; cmd_phy = phy; cmd_reg = rg; cmd_data = wd;
    cmd_valid[dut] = 1'b1;
    k = 0;
    while (!cmd_ready[dut] && k < 2000) begin
      @(negedge clk);
      k++;
    end
    #1;
    chk("accept_ready",   64'(cmd_ready[dut]), 64'd1);
    chk("busy_on_accept", 64'(busy[dut]),      64'd1);
    n = cyc;
    if (push) begin
      e.dut = dut; e.data = e_data; e.err = e_err; e.due = n + lat;
      e.strm = e_strm; e.oen = e_oen; e.rises = e_rises;
      sb.push_back(e);
    end
    @(negedge clk);
    cmd_valid[dut] = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
    @(negedge clk);
  endtask

  localparam logic [63:0] OEN_RD = 64'h3FFFF;

  initial begin
    int n, n1, n2;
    logic [63:0] s_wr, s_rd, s_wr2, s_c45a, s_c45r;
    s_wr   = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd1, 5'd0, 2'b10, 16'h1140};
    s_rd   = {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd1, 5'd1, 18'h3FFFF};
    s_wr2  = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd2, 5'd3, 2'b10, 16'hA5A5};
    s_c45a = {32'h0, 2'b00, 2'b00, 5'd3, 5'd1, 2'b10, 16'h0007};
    s_c45r = {32'h0, 2'b00, 2'b10, 5'd3, 5'd1, 18'h3FFFF};

    rst = 1'b1; cmd_valid = 2'b00; cmd_c45 = 1'b0; cmd_op = 2'b00;
    cmd_phy = 5'd0; cmd_reg = 5'd0; cmd_data = 16'h0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_state",
          64'({mdc[i], mdio_out[i], mdio_oen[i], cmd_ready[i], rsp_valid[i], rsp_err[i], busy[i], rsp_data[i]}),
          64'({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000}));
    end
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'(cmd_ready), 64'b11);

    // C22 write, full preamble.
    issue(0, 1'b0, 2'b01, 5'd1, 5'd0, 16'h1140, 1, 257, 16'h0000, 1'b0, s_wr, 64'h0, 64, n);
    drain();

    // C22 read with a PHY present.
    phy_on = 1'b1; phy_word = 16'h796D;
    issue(0, 1'b0, 2'b10, 5'd1, 5'd1, 16'h0000, 1, 257, 16'h796D, 1'b0, s_rd, OEN_RD, 64, n);
    phy_n = n;
    drain();

    // C22 read with no PHY: pad stays high.
    phy_on = 1'b0;
    issue(0, 1'b0, 2'b10, 5'd1, 5'd1, 16'h0000, 1, 257, 16'hFFFF, 1'b1, s_rd, OEN_RD, 64, n);
    drain();

    // Illegal C22 op 11: immediate error response, no frame.
    issue(0, 1'b0, 2'b11, 5'd1, 5'd1, 16'h1234, 1, 1, 16'h0000, 1'b1, 64'h0, 64'h0, 0, n);
    drain();

    // Clause 45 request on the C22-only instance falls back to a C22 write.
    issue(0, 1'b1, 2'b01, 5'd2, 5'd3, 16'hA5A5, 1, 257, 16'h0000, 1'b0, s_wr2, 64'h0, 64, n);
    drain();

    // C45 address then read-increment, back to back, no preamble.
    issue(1, 1'b1, 2'b00, 5'd3, 5'd1, 16'h0007, 1, 129, 16'h0000, 1'b0, s_c45a, 64'h0, 32, n1);
    issue(1, 1'b1, 2'b10, 5'd3, 5'd1, 16'h0000, 1, 129, 16'hFFFF, 1'b1, s_c45r, OEN_RD, 32, n2);
    chk("b2b_spacing", 64'(n2 - n1), 64'd130);
    drain();

    // Reset during bit 20 of a write: frame abandoned, no response.
    issue(0, 1'b0, 2'b01, 5'd1, 5'd0, 16'h1140, 0, 0, 16'h0, 1'b0, 64'h0, 64'h0, 0, n);
    while (cyc < n + 1 + 20 * 2 * D + 1) @(negedge clk);
    chk("busy_mid_frame", 64'(busy[0]), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_pins", 64'({mdc[0], mdio_out[0], mdio_oen[0]}), 64'b011);
    chk("abort_flags", 64'({busy[0], rsp_valid[0], cmd_ready[0]}), 64'b000);
    chk("abort_rsp_data", 64'(rsp_data[0]), 64'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_abort", 64'(cmd_ready[0]), 64'd1);
    repeat (20) @(negedge clk);
    issue(0, 1'b0, 2'b01, 5'd1, 5'd0, 16'h1140, 1, 257, 16'h0000, 1'b0, s_wr, 64'h0, 64, n);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
